serial_word_tx: RTL and testbench

- Parallel-in, serial-out transmitter for the sequential adder datapath.
- Loads a WIDTH-bit operand and shifts it out one bit per enabled cycle, LSB first.
- Its output feeds the serial input of the right-shifting collector register, which takes each new bit at its MSB. After WIDTH enabled cycles, the collector holds the original word.
- Provides start/busy/done handshaking and a bit index so the adder controller can sequence operands.

---
 rtl/serial_word_tx.sv | 115 +++++++++++
 tb/tb_serial_word_tx.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/serial_word_tx.sv
// rtl/serial_word_tx.sv - LSB-first parallel-in serial-out word transmitter with start/busy/done handshake
// Optional even-parity trailer bit enabled by defining SERIAL_TX_PARITY_EN.
module serial_word_tx #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 2)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             start,
    input  logic             en,
    output logic             sout,
    output logic             sout_valid,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] bit_idx
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

`ifdef SERIAL_TX_PARITY_EN
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH);
`else
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);
`endif

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] sreg;
    logic [CNT_W-1:0] cnt;
    logic             load;
    logic             shift;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        shift      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (en) begin
                    shift = 1'b1;
                    if (cnt == LAST) begin
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                // Back-to-back start is accepted while the done pulse is out.
                if (start) begin
                    load       = 1'b1;
                    state_next = SHIFT;
                end else begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // cnt returns to 0 on the final shift so bit_idx reads 0 in DONE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sreg <= '0;
            cnt  <= '0;
        end else if (load) begin
            sreg <= din;
            cnt  <= '0;
        end else if (shift) begin
            sreg <= {1'b0, sreg[WIDTH-1:1]};
            cnt  <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end
    end

`ifdef SERIAL_TX_PARITY_EN
    logic parity;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            parity <= 1'b0;
        end else if (load) begin
            parity <= ^din;
        end
    end

    assign sout = (cnt == CNT_W'(WIDTH)) ? parity : sreg[0];
`else
    assign sout = sreg[0];
`endif

    assign busy       = (state == SHIFT);
    assign sout_valid = busy & en;
    assign done       = (state == DONE);
    assign bit_idx    = cnt;

endmodule

// File: tb/tb_serial_word_tx.sv
// tb/tb_serial_word_tx.sv - directed self-checking bench for serial_word_tx
module tb_serial_word_tx;

`ifdef SERIAL_TX_PARITY_EN
    localparam int NB = 9;
`else
    localparam int NB = 8;
`endif

    logic       clk;
    logic       rst;
    logic [7:0] din;
    logic       start;
    logic       en;
    logic       sout;
    logic       sout_valid;
    logic       busy;
    logic       done;
    logic [3:0] bit_idx;

    int         checks;
    int         errors;
    logic [7:0] col;

    serial_word_tx #(.WIDTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .start      (start),
        .en         (en),
        .sout       (sout),
        .sout_valid (sout_valid),
        .busy       (busy),
        .done       (done),
        .bit_idx    (bit_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".sout"}, 32'(sout), 32'd0);
        chk({tag, ".valid"}, 32'(sout_valid), 32'd0);
        chk({tag, ".busy"}, 32'(busy), 32'd0);
        chk({tag, ".done"}, 32'(done), 32'd0);
        chk({tag, ".idx"}, 32'(bit_idx), 32'd0);
    endtask

    // Entered at the negedge of the first bit cycle; leaves at the negedge after the done cycle.
    task automatic frame(input logic [7:0] w, input int stall_at, input int stall_n,
                         input int start_bit, input logic [7:0] sdin,
                         input logic start_done, input logic [7:0] ndin);
        logic exp_bit;
        col = 8'h00;
        for (int i = 0; i < NB; i++) begin
            exp_bit = (i < 8) ? w[i] : ^w;
            if (i == stall_at) begin
                for (int s = 0; s < stall_n; s++) begin
                    en    = 1'b0;
                    start = 1'b0;
                    #1;
                    chk($sformatf("stall%0d.sout", i), 32'(sout), 32'(exp_bit));
                    chk($sformatf("stall%0d.valid", i), 32'(sout_valid), 32'd0);
                    chk($sformatf("stall%0d.idx", i), 32'(bit_idx), 32'(i));
                    chk($sformatf("stall%0d.busy", i), 32'(busy), 32'd1);
                    @(negedge clk);
                end
            end
            en    = 1'b1;
            start = (i == start_bit);
            if (i == start_bit) din = sdin;
            #1;
            chk($sformatf("bit%0d.sout", i), 32'(sout), 32'(exp_bit));
            chk($sformatf("bit%0d.valid", i), 32'(sout_valid), 32'd1);
            chk($sformatf("bit%0d.idx", i), 32'(bit_idx), 32'(i));
            chk($sformatf("bit%0d.done", i), 32'(done), 32'd0);
            if (i < 8) col = {sout, col[7:1]};
            @(negedge clk);
        end
        start = start_done;
        din   = ndin;
        #1;
        chk("done.done", 32'(done), 32'd1);
        chk("done.busy", 32'(busy), 32'd0);
        chk("done.valid", 32'(sout_valid), 32'd0);
        chk("done.idx", 32'(bit_idx), 32'd0);
        chk("collector", 32'(col), 32'(w));
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        din    = 8'h5A;
        start  = 1'b1;
        en     = 1'b1;
        #2 rst = 1'b0;
        #1;
        chk_zero("rst_async");
        @(posedge clk);
        #1;
        chk_zero("rst_held");
        @(negedge clk);
        rst   = 1'b1;
        start = 1'b0;
        repeat (2) begin
            @(negedge clk);
            #1;
            chk("idle.busy", 32'(busy), 32'd0);
            chk("idle.done", 32'(done), 32'd0);
        end

        // Plain transfer of 8'hB4
        din   = 8'hB4;
        start = 1'b1;
        @(negedge clk);
        frame(8'hB4, -1, 0, -1, 8'h00, 1'b0, 8'h00);
        #1;
        chk("post_done.done", 32'(done), 32'd0);
        chk("post_done.busy", 32'(busy), 32'd0);

        // Three-cycle stall while bit 3 is on the line
        @(negedge clk);
        din   = 8'hB4;
        start = 1'b1;
        @(negedge clk);
        frame(8'hB4, 3, 3, -1, 8'h00, 1'b0, 8'h00);

        // Ignored start mid-frame, then back-to-back start in the done cycle
        din   = 8'h0F;
        start = 1'b1;
        @(negedge clk);
        frame(8'h0F, -1, 0, 2, 8'hFF, 1'b1, 8'h81);
        frame(8'h81, -1, 0, -1, 8'h00, 1'b0, 8'h00);

        // Asynchronous abort during bit 4 of 8'hA5
        din   = 8'hA5;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("a5_bit%0d", i), 32'(sout), 32'(i % 2 == 0 ? 1 : 0));
            @(negedge clk);
        end
        #1;
        chk("a5_bit4.idx", 32'(bit_idx), 32'd4);
        #1 rst = 1'b0;
        #1;
        chk_zero("abort");
        @(negedge clk);
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            #1;
            chk("abort.nodone", 32'(done), 32'd0);
            chk("abort.busy", 32'(busy), 32'd0);
        end
        din   = 8'h3C;
        start = 1'b1;
        @(negedge clk);
        frame(8'h3C, -1, 0, -1, 8'h00, 1'b0, 8'h00);

`ifdef SERIAL_TX_PARITY_EN
        din   = 8'h07;
        start = 1'b1;
        @(negedge clk);
        frame(8'h07, 8, 2, -1, 8'h00, 1'b0, 8'h00);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
